// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ / IDX_W : requester count and grant index width
//   state_t         : arbiter FSM encoding (IDLE = no grant, GRANT = owned)
//   rr_pick()       : round-robin winner search starting at a pointer
package rr_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate req so that bit ptr lands at position 0, pick the lowest set bit,
  // then add ptr back (modulo 8 via the 3-bit wrap). The loop unrolls into a
  // plain priority mux over the rotated vector; there is no feedback path.
  // Caller guarantees req != 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    dbl = {req, req};
    rot = dbl[ptr +: NUM_REQ];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    return ptr + off;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_onehot_dec3.sv
// 3-to-8 one-hot decoder used to form the grant vector.
//   idx    : binary index
//   onehot : bit idx set, all others clear
module onehot_dec3
  import rr_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bit
    assign onehot[i] = (idx == IDX_W'(i));
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with hold-time limit.
//   Clk       : system clock, rising edge
//   Rst       : synchronous active-high reset
//   req       : request vector, bit i = requester i
//   done      : release strobe from the current owner (ignored when idle)
//   gnt       : registered one-hot grant, zero when idle
//   gnt_idx   : registered binary index of the owner, valid with gnt_valid
//   gnt_valid : grant active
//   timeout   : one-cycle pulse when a grant was forced off by MAX_HOLD
// Every grant is followed by one idle cycle before the next arbitration.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_d, timeout_d;
  logic [NUM_REQ-1:0] gnt_d, dec_oh;
  logic               hold_hit, own_req;

  // Decode the next-cycle index so gnt itself can be a flop.
  onehot_dec3 u_dec (
    .idx    (idx_d),
    .onehot (dec_oh)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = gnt_idx;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    hold_hit  = 1'b0;
    own_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, ptr_q);
          hold_d  = '0;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        hold_hit = (hold_q == HOLD_LAST);
        own_req  = req[gnt_idx];
        if (done || !own_req || hold_hit) begin
          state_d   = IDLE;
          ptr_d     = gnt_idx + 3'd1;
          // Only a release forced purely by the limit counts as a timeout.
          timeout_d = hold_hit && !done && own_req;
        end else begin
          valid_d = 1'b1;
          if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = valid_d ? dec_oh : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
    logic       idx_chk;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc_cnt = 0;
  int    checks  = 0;
  int    errors  = 0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s %s got %h want %h", nm, fld, act, want);
    end
  endtask

  // Monitor: compares DUT outputs against the entry scheduled for this cycle.
  exp_t  mon_e;
  string mon_nm;
  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL %s cycle got %0d want %0d", mon_nm, cyc_cnt, mon_e.cyc);
      end
      chk(mon_nm, "gnt",       gnt,               mon_e.gnt);
      chk(mon_nm, "gnt_valid", {7'd0, gnt_valid}, {7'd0, mon_e.valid});
      chk(mon_nm, "timeout",   {7'd0, timeout},   {7'd0, mon_e.to});
      if (mon_e.idx_chk)
        chk(mon_nm, "gnt_idx", {5'd0, gnt_idx}, {5'd0, mon_e.idx});
    end
  end

  // Drive one cycle of inputs and schedule the outputs expected after the edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei,
                      input logic ev, input logic et, input string nm);
    exp_t e;
    Rst  = r;
    req  = rq;
    done = d;
    e.cyc     = cyc_cnt + 1;
    e.gnt     = eg;
    e.idx     = ei;
    e.valid   = ev;
    e.to      = et;
    e.idx_chk = ev || r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no_finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    // reset, including with live inputs
    step(1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rst0");
    step(1, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "rst1");
    // single requester, done release, pointer advance to 1
    step(0, 8'h01, 0, 8'h01, 3'd0, 1, 0, "r29_grant");
    step(0, 8'h01, 1, 8'h00, 3'd0, 0, 0, "r29_done");
    step(0, 8'h03, 0, 8'h02, 3'd1, 1, 0, "r29_ptr1");
    step(0, 8'h03, 1, 8'h00, 3'd0, 0, 0, "r29_rel");
    // reset mid-grant (ptr=2 here), then scan restarts at 0
    step(0, 8'hFF, 0, 8'h04, 3'd2, 1, 0, "r34_grant");
    step(0, 8'hFF, 0, 8'h04, 3'd2, 1, 0, "r34_hold");
    step(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, "r34_rst");
    step(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, "r34_rst2");
    step(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0, "r34_first");
    // all requesting: 0 -> 1 -> ... -> 7 -> 0 with an idle cycle between
    for (int i = 1; i <= 8; i++) begin
      oh = 8'h01 << (i % 8);
      step(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "r30_rel");
      step(0, 8'hFF, 0, oh, 3'(i % 8), 1, 0, "r30_grant");
    end
    step(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "r30_end");
    // get ptr to 3, then wrap-around: 7 first, then 2
    step(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "r31_set");
    step(0, 8'h04, 1, 8'h00, 3'd0, 0, 0, "r31_setrel");
    step(0, 8'h84, 0, 8'h80, 3'd7, 1, 0, "r31_wrap7");
    step(0, 8'h84, 1, 8'h00, 3'd0, 0, 0, "r31_rel7");
    step(0, 8'h84, 0, 8'h04, 3'd2, 1, 0, "r31_then2");
    // other req bits toggle without effect, owner drop releases
    step(0, 8'hA4, 0, 8'h04, 3'd2, 1, 0, "r33_tog5a");
    step(0, 8'h84, 0, 8'h04, 3'd2, 1, 0, "r33_tog5b");
    step(0, 8'h80, 0, 8'h00, 3'd0, 0, 0, "r33_drop");
    // requester 7 drops during the idle cycle; ptr=3 scan finds 0
    step(0, 8'h01, 0, 8'h01, 3'd0, 1, 0, "r22_dropped");
    step(0, 8'h01, 1, 8'h00, 3'd0, 0, 0, "r22_rel");
    // hold limit 4: four grant cycles, timeout pulse, re-grant
    step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "r32_grant");
    for (int i = 0; i < 3; i++)
      step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "r32_hold");
    step(0, 8'h10, 0, 8'h00, 3'd0, 0, 1, "r32_timeout");
    step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "r32_regrant");
    // done coinciding with the limit is a normal release
    for (int i = 0; i < 3; i++)
      step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "r19_hold");
    step(0, 8'h10, 1, 8'h00, 3'd0, 0, 0, "r19_done_limit");
    // done while idle is ignored
    step(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, "r21_idle_done");
    step(0, 8'h20, 1, 8'h20, 3'd5, 1, 0, "r21_done_ignored");
    step(0, 8'h20, 1, 8'h00, 3'd0, 0, 0, "r21_rel");
    step(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "r21_quiet");

    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum number of cycles one grant is held before forced release (legal range 2..255).
REQ-002 Clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  release strobe from the current grant holder; ignored unless a grant is active.
REQ-006 gnt  output  8  one-hot grant vector; all-zero when no grant is active.
REQ-007 gnt_idx  output  3  binary index of the granted requester; valid only while gnt_valid=1.
REQ-008 gnt_valid  output  1  high while a grant is active.
REQ-009 timeout  output  1  single-cycle pulse when a grant is force-released by the hold limit.

Function
REQ-010 The FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-011 In IDLE with req!=0 at edge N, the block SHALL enter GRANT with gnt valid from cycle N+1 (1-cycle latency).
REQ-012 Winner selection SHALL scan req starting at pointer ptr, then ptr+1, and so on modulo 8; the first set bit wins.
REQ-013 ptr SHALL be 3 bits, SHALL wrap from 7 to 0, and SHALL be loaded with (winner+1) mod 8 on every release.
REQ-014 gnt SHALL always equal the 3-to-8 one-hot decode of gnt_idx when gnt_valid=1, and SHALL be 8'h00 otherwise.
REQ-015 In GRANT, release SHALL occur on the first cycle in which any of these holds: done=1; req[gnt_idx]=0; hold counter = MAX_HOLD-1.
REQ-016 On release the block SHALL return to IDLE for exactly one cycle (gnt=0), then re-arbitrate; back-to-back grants are therefore separated by one idle cycle.
REQ-017 The hold counter SHALL clear on entry to GRANT and increment by 1 each GRANT cycle; it SHALL saturate and never wrap.
REQ-018 timeout SHALL pulse for one cycle, coincident with the first IDLE cycle, only when the release was caused by the hold limit alone (done=0 and req[gnt_idx]=1).
REQ-019 If done and the hold limit coincide, the release SHALL count as normal and timeout SHALL stay 0.
REQ-020 Changes on req bits other than gnt_idx during GRANT SHALL NOT affect the current grant.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 A requester dropping req during the IDLE cycle between grants SHALL NOT be granted.
REQ-023 No combinational path SHALL exist from req or done to any output; all outputs SHALL be registered.

Reset
REQ-024 While Rst=1 at a rising edge: state=IDLE, ptr=0, hold counter=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
REQ-025 Rst asserted mid-grant SHALL drop the grant on the next edge with no timeout pulse; the first arbitration after reset SHALL start the scan at requester 0.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, GRANT=1'b1), the requester count (8), and the index width (3).
REQ-027 The index-to-one-hot conversion SHALL be a separate combinational sub-module named onehot_dec3 (3-bit in, 8-bit one-hot out), instantiated once.
REQ-028 The round-robin search SHALL be a fixed-width rotate-and-priority-encode, with no loop-carried combinational feedback.

Verification
REQ-029 Reset, then req=8'h01 -> gnt=8'h01 and gnt_idx=0 one cycle later; done pulse -> gnt=8'h00 next cycle, ptr=1.
REQ-030 req=8'hFF held, done pulsed each grant -> grants cycle 0,1,...,7,0 with one idle cycle between consecutive grants.
REQ-031 req=8'h84 with ptr=3 -> first grant to index 7 (gnt=8'h80), then to index 2 (gnt=8'h04); exercises wrap-around.
REQ-032 MAX_HOLD=4, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then re-grant to index 4.
REQ-033 During a grant to index 2, deassert req[2] -> release on the next edge with timeout=0; toggling req[5] during that grant -> no change.
REQ-034 Rst=1 mid-grant with req=8'hFF -> outputs return to their reset values; after Rst falls, the first grant goes to index 0.
